// File: rtl/green_buffer_arbiter.sv
`timescale 1ns/1ps
// green_buffer_arbiter
//
// Write-side controller for the green frame buffer. A raster camera stream
// (coordinates generated here) and a random-access draw engine (explicit
// coordinates) share the buffer's single write port under round-robin
// arbitration. A frame-aligned freeze control suppresses camera writes so a
// stable image can be held while the draw engine keeps writing.
//
// Ports:
//   CLOCK_50                single clock, rising edge
//   reset_n                 asynchronous active-low reset
//   cam_valid/cam_ready     camera handshake (ready is combinational)
//   cam_data, cam_sof       camera pixel, start-of-frame marker
//   drw_valid/drw_ready     draw handshake (ready is combinational)
//   drw_data, drw_x, drw_y  draw pixel and coordinates
//   freeze_req              level: 1 = hold image, 0 = live
//   buf_we, buf_data,
//   buf_wx, buf_wy          registered buffer write port
//   frozen                  camera writes currently suppressed
//   frame_done              pulse, last camera pixel of a frame accepted
//   sync_err                pulse, cam_sof seen with counters not at (0,0)
//   drw_drop                pulse, out-of-range draw beat discarded
module green_buffer_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int COORD_W  = 11,
    parameter int DATA_W   = 8
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic               cam_valid,
    output logic               cam_ready,
    input  logic [DATA_W-1:0]  cam_data,
    input  logic               cam_sof,
    input  logic               drw_valid,
    output logic               drw_ready,
    input  logic [DATA_W-1:0]  drw_data,
    input  logic [COORD_W-1:0] drw_x,
    input  logic [COORD_W-1:0] drw_y,
    input  logic               freeze_req,
    output logic               buf_we,
    output logic [DATA_W-1:0]  buf_data,
    output logic [COORD_W-1:0] buf_wx,
    output logic [COORD_W-1:0] buf_wy,
    output logic               frozen,
    output logic               frame_done,
    output logic               sync_err,
    output logic               drw_drop
);

    typedef enum logic [1:0] {RUN, FRZ_PEND, FROZEN, THAW_PEND} state_t;

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);
    localparam logic [COORD_W-1:0] X_LIM  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] Y_LIM  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

    state_t             state;
    state_t             state_nxt;
    logic               ptr_drw;
    logic [COORD_W-1:0] cam_x;
    logic [COORD_W-1:0] cam_y;
    logic [COORD_W-1:0] cam_x_nxt;
    logic [COORD_W-1:0] cam_y_nxt;

    logic contention;
    logic cam_acc;
    logic drw_acc;
    logic cam_last;
    logic boundary;
    logic drw_in_range;
    logic cam_wr;
    logic drw_wr;

    // While frozen the camera no longer needs the write port, so both sides
    // are simply accepted and there is never any contention.
    assign frozen     = (state == FROZEN) || (state == THAW_PEND);
    assign contention = cam_valid && drw_valid && !frozen;

    // Readies are forced low while reset is held so nothing is consumed.
    always_comb begin
        cam_ready = 1'b0;
        drw_ready = 1'b0;
        if (reset_n) begin
            if (contention) begin
                cam_ready = !ptr_drw;
                drw_ready = ptr_drw;
            end else begin
                cam_ready = cam_valid;
                drw_ready = drw_valid;
            end
        end
    end

    assign cam_acc      = cam_valid && cam_ready;
    assign drw_acc      = drw_valid && drw_ready;
    // An sof beat always lands at (0,0), so it can never be the last pixel.
    assign cam_last     = (cam_x == X_LAST) && (cam_y == Y_LAST) && !cam_sof;
    assign boundary     = cam_acc && (cam_sof || cam_last);
    assign drw_in_range = (drw_x < X_LIM) && (drw_y < Y_LIM);
    assign cam_wr       = cam_acc && !frozen;
    assign drw_wr       = drw_acc && drw_in_range;

    // Raster position after the current camera beat. An sof beat resyncs
    // the counters so the following pixel goes to (1,0).
    always_comb begin
        cam_x_nxt = cam_x;
        cam_y_nxt = cam_y;
        if (cam_sof) begin
            cam_x_nxt = ONE;
            cam_y_nxt = '0;
        end else if (cam_x == X_LAST) begin
            cam_x_nxt = '0;
            cam_y_nxt = (cam_y == Y_LAST) ? '0 : cam_y + ONE;
        end else begin
            cam_x_nxt = cam_x + ONE;
        end
    end

    // Counters advance on every accepted camera beat, frozen or not, so the
    // raster stays aligned with the incoming stream.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cam_x <= '0;
            cam_y <= '0;
        end else if (cam_acc) begin
            cam_x <= cam_x_nxt;
            cam_y <= cam_y_nxt;
        end
    end

    // Freeze control: requests take effect only at a frame boundary, and a
    // pending request can be withdrawn before the boundary arrives.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:       if (freeze_req) state_nxt = FRZ_PEND;
            FRZ_PEND:  if (!freeze_req) state_nxt = RUN;
                       else if (boundary) state_nxt = FROZEN;
            FROZEN:    if (!freeze_req) state_nxt = THAW_PEND;
            THAW_PEND: if (freeze_req) state_nxt = FROZEN;
                       else if (boundary) state_nxt = RUN;
            default:   state_nxt = RUN;
        endcase
    end

    // State register and round-robin pointer; the pointer only moves to the
    // loser when both sides actually competed.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RUN;
            ptr_drw <= 1'b0;
        end else begin
            state <= state_nxt;
            if (contention) begin
                ptr_drw <= !ptr_drw;
            end
        end
    end

    // Registered write port and status pulses. Camera and draw writes are
    // mutually exclusive: unfrozen only one side is granted, frozen the
    // camera never writes. Data and coordinates hold between writes.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            buf_we     <= 1'b0;
            buf_data   <= '0;
            buf_wx     <= '0;
            buf_wy     <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            drw_drop   <= 1'b0;
        end else begin
            buf_we     <= cam_wr || drw_wr;
            frame_done <= cam_acc && cam_last;
            sync_err   <= cam_acc && cam_sof && ((cam_x != '0) || (cam_y != '0));
            drw_drop   <= drw_acc && !drw_in_range;
            if (cam_wr) begin
                buf_data <= cam_data;
                buf_wx   <= cam_sof ? '0 : cam_x;
                buf_wy   <= cam_sof ? '0 : cam_y;
            end else if (drw_wr) begin
                buf_data <= drw_data;
                buf_wx   <= drw_x;
                buf_wy   <= drw_y;
            end
        end
    end

endmodule

// File: tb/tb_green_buffer_arbiter.sv
`timescale 1ns/1ps
// tb_green_buffer_arbiter
//
// Self-checking bench for green_buffer_arbiter, built on a reduced 20x6
// geometry so whole frames fit in a short run. A reference model tracks the
// camera as a linear pixel index, the freeze as a held/requested pair and
// the arbiter as a preferred side; every cycle the DUT is compared with it.
module tb_green_buffer_arbiter;

    localparam int TB_H  = 20;
    localparam int TB_V  = 6;
    localparam int FRAME = TB_H * TB_V;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic        cam_valid;
    logic        cam_ready;
    logic [7:0]  cam_data;
    logic        cam_sof;
    logic        drw_valid;
    logic        drw_ready;
    logic [7:0]  drw_data;
    logic [10:0] drw_x;
    logic [10:0] drw_y;
    logic        freeze_req;
    logic        buf_we;
    logic [7:0]  buf_data;
    logic [10:0] buf_wx;
    logic [10:0] buf_wy;
    logic        frozen;
    logic        frame_done;
    logic        sync_err;
    logic        drw_drop;

    green_buffer_arbiter #(
        .H_ACTIVE(TB_H),
        .V_ACTIVE(TB_V),
        .COORD_W (11),
        .DATA_W  (8)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .cam_valid (cam_valid),
        .cam_ready (cam_ready),
        .cam_data  (cam_data),
        .cam_sof   (cam_sof),
        .drw_valid (drw_valid),
        .drw_ready (drw_ready),
        .drw_data  (drw_data),
        .drw_x     (drw_x),
        .drw_y     (drw_y),
        .freeze_req(freeze_req),
        .buf_we    (buf_we),
        .buf_data  (buf_data),
        .buf_wx    (buf_wx),
        .buf_wy    (buf_wy),
        .frozen    (frozen),
        .frame_done(frame_done),
        .sync_err  (sync_err),
        .drw_drop  (drw_drop)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_pos;
    bit m_held;
    bit m_req_prev;
    bit m_prefer_cam;
    bit e_we, e_fd, e_se, e_dd;
    int e_data, e_wx, e_wy;

    typedef struct {
        bit cv;
        bit sof;
        int cdata;
        bit dv;
        int dx;
        int dy;
        int ddata;
        bit x_cr;
        bit x_dr;
        bit x_we;
        int x_data;
        int x_wx;
        int x_wy;
        bit x_se;
        bit x_dd;
    } vec_t;

    vec_t vq[$];

    task automatic checkValue(input string name, input int actual, input int required);
        n_cmp++;
        if (actual != required) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, required, $time);
        end
    endtask

    task automatic modelReset();
        m_pos        = 0;
        m_held       = 1'b0;
        m_req_prev   = 1'b0;
        m_prefer_cam = 1'b1;
        e_we = 0; e_fd = 0; e_se = 0; e_dd = 0;
        e_data = 0; e_wx = 0; e_wy = 0;
    endtask

    // Drive one cycle of inputs, check the readies against the model and
    // work out what the write port must show after the coming edge.
    task automatic applyStimulus(input bit cv, input bit sof, input int cdata,
                                 input bit dv, input int dx, input int dy,
                                 input int ddata, input bit frz);
        bit gc, gd, bnd;
        int wpos;
        cam_valid  = cv;
        cam_sof    = sof;
        cam_data   = 8'(cdata);
        drw_valid  = dv;
        drw_x      = 11'(dx);
        drw_y      = 11'(dy);
        drw_data   = 8'(ddata);
        freeze_req = frz;
        #1;
        if (!m_held && cv && dv) begin
            gc = m_prefer_cam;
            gd = !m_prefer_cam;
            m_prefer_cam = !m_prefer_cam;
        end else begin
            gc = cv;
            gd = dv;
        end
        checkValue("cam_ready", cam_ready, gc);
        checkValue("drw_ready", drw_ready, gd);
        e_we = 0; e_fd = 0; e_se = 0; e_dd = 0;
        bnd = 0;
        if (gc) begin
            if (sof) begin
                wpos  = 0;
                e_se  = (m_pos != 0);
                m_pos = 1;
                bnd   = 1;
            end else begin
                wpos  = m_pos;
                e_fd  = (m_pos == FRAME - 1);
                bnd   = e_fd;
                m_pos = (m_pos + 1) % FRAME;
            end
            if (!m_held) begin
                e_we   = 1;
                e_data = cdata & 255;
                e_wx   = wpos % TB_H;
                e_wy   = wpos / TB_H;
            end
        end
        if (gd) begin
            if (dx < TB_H && dy < TB_V) begin
                e_we   = 1;
                e_data = ddata & 255;
                e_wx   = dx;
                e_wy   = dy;
            end else begin
                e_dd = 1;
            end
        end
        // A change of hold state needs the request to have been standing
        // before this edge and still be standing on it, at a boundary.
        if (bnd && frz != m_held && m_req_prev != m_held) m_held = !m_held;
        m_req_prev = frz;
    endtask

    task automatic checkOutput();
        checkValue("buf_we", buf_we, e_we);
        if (e_we) begin
            checkValue("buf_data", buf_data, e_data);
            checkValue("buf_wx", buf_wx, e_wx);
            checkValue("buf_wy", buf_wy, e_wy);
        end
        checkValue("frame_done", frame_done, e_fd);
        checkValue("sync_err", sync_err, e_se);
        checkValue("drw_drop", drw_drop, e_dd);
        checkValue("frozen", frozen, m_held);
    endtask

    task automatic cycle(input bit cv, input bit sof, input int cdata,
                         input bit dv, input int dx, input int dy,
                         input int ddata, input bit frz);
        applyStimulus(cv, sof, cdata, dv, dx, dy, ddata, frz);
        @(posedge CLOCK_50);
        #1;
        checkOutput();
    endtask

    task automatic idleInputs();
        cam_valid = 0; cam_sof = 0; cam_data = 0;
        drw_valid = 0; drw_x = 0; drw_y = 0; drw_data = 0;
        freeze_req = 0;
    endtask

    task automatic doReset();
        idleInputs();
        reset_n = 0;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset_n = 1;
        modelReset();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic addVec(input bit cv, input bit sof, input int cdata,
                          input bit dv, input int dx, input int dy, input int ddata,
                          input bit x_cr, input bit x_dr, input bit x_we,
                          input int x_data, input int x_wx, input int x_wy,
                          input bit x_se, input bit x_dd);
        vec_t v;
        v.cv = cv; v.sof = sof; v.cdata = cdata;
        v.dv = dv; v.dx = dx; v.dy = dy; v.ddata = ddata;
        v.x_cr = x_cr; v.x_dr = x_dr; v.x_we = x_we;
        v.x_data = x_data; v.x_wx = x_wx; v.x_wy = x_wy;
        v.x_se = x_se; v.x_dd = x_dd;
        vq.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fd_count, we_count, drw_count;
        bit frz_r, dvb;
        modelReset();

        // Reset state, with requests present to show readies stay low
        idleInputs();
        reset_n = 0;
        #3;
        cam_valid = 1;
        drw_valid = 1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        checkValue("reset cam_ready", cam_ready, 0);
        checkValue("reset drw_ready", drw_ready, 0);
        checkValue("reset buf_we", buf_we, 0);
        checkValue("reset buf_data", buf_data, 0);
        checkValue("reset buf_wx", buf_wx, 0);
        checkValue("reset buf_wy", buf_wy, 0);
        checkValue("reset frozen", frozen, 0);
        checkValue("reset frame_done", frame_done, 0);
        checkValue("reset sync_err", sync_err, 0);
        checkValue("reset drw_drop", drw_drop, 0);
        doReset();
        checkOutput();

        // Directed vectors from reset: pointer starts on camera
        //      cv sof cdat dv  dx    dy   ddat  cr dr we data  wx  wy  se dd
        addVec(1, 0, 'h11, 0, 0,    0,   0,    1, 0, 1, 'h11, 0,  0,  0, 0);
        addVec(1, 0, 'h22, 0, 0,    0,   0,    1, 0, 1, 'h22, 1,  0,  0, 0);
        addVec(0, 0, 0,    1, TB_H, 2,   'h33, 0, 1, 0, 0,    0,  0,  0, 1);
        addVec(0, 0, 0,    1, TB_H-1, TB_V-1, 'h5A, 0, 1, 1, 'h5A, TB_H-1, TB_V-1, 0, 0);
        addVec(1, 0, 'h44, 1, 3,    3,   'h55, 1, 0, 1, 'h44, 2,  0,  0, 0);
        addVec(1, 0, 'h66, 1, 3,    3,   'h77, 0, 1, 1, 'h77, 3,  3,  0, 0);
        addVec(1, 0, 'h88, 1, 4,    4,   'h99, 1, 0, 1, 'h88, 3,  0,  0, 0);
        addVec(0, 0, 0,    1, 5,    1,   'h9B, 0, 1, 1, 'h9B, 5,  1,  0, 0);
        addVec(1, 0, 'hAA, 1, 0,    TB_V,'hBB, 0, 1, 0, 0,    0,  0,  0, 1);
        addVec(1, 1, 'hCC, 0, 0,    0,   0,    1, 0, 1, 'hCC, 0,  0,  1, 0);
        addVec(1, 0, 'hDD, 0, 0,    0,   0,    1, 0, 1, 'hDD, 1,  0,  0, 0);
        addVec(0, 0, 0,    1, 2047, 0,   'h01, 0, 1, 0, 0,    0,  0,  0, 1);
        addVec(0, 0, 0,    1, 0,    0,   'hEE, 0, 1, 1, 'hEE, 0,  0,  0, 0);
        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(vq[i].cv, vq[i].sof, vq[i].cdata, vq[i].dv,
                          vq[i].dx, vq[i].dy, vq[i].ddata, 0);
            checkValue($sformatf("vec%0d cam_ready", i), cam_ready, vq[i].x_cr);
            checkValue($sformatf("vec%0d drw_ready", i), drw_ready, vq[i].x_dr);
            @(posedge CLOCK_50);
            #1;
            checkOutput();
            checkValue($sformatf("vec%0d buf_we", i), buf_we, vq[i].x_we);
            if (vq[i].x_we) begin
                checkValue($sformatf("vec%0d buf_data", i), buf_data, vq[i].x_data);
                checkValue($sformatf("vec%0d buf_wx", i), buf_wx, vq[i].x_wx);
                checkValue($sformatf("vec%0d buf_wy", i), buf_wy, vq[i].x_wy);
            end
            checkValue($sformatf("vec%0d sync_err", i), sync_err, vq[i].x_se);
            checkValue($sformatf("vec%0d drw_drop", i), drw_drop, vq[i].x_dd);
        end

        // Full camera frame starting with sof
        fd_count = 0;
        for (int i = 0; i < FRAME; i++) begin
            cycle(1, i == 0, (i * 7) & 255, 0, 0, 0, 0, 0);
            checkValue("frame buf_wx", buf_wx, i % TB_H);
            checkValue("frame buf_wy", buf_wy, i / TB_H);
            if (frame_done) fd_count++;
        end
        checkValue("frame last write wx", buf_wx, TB_H - 1);
        checkValue("frame last write wy", buf_wy, TB_V - 1);
        checkValue("frame_done count", fd_count, 1);

        // Both requesters every cycle: alternate grants, a write every cycle
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 'h30 + i, 1, i, 2, 'h60 + i, 0);
            checkValue("contention buf_we", buf_we, 1);
        end
        doReset();

        // Freeze requested mid-frame, takes hold at the frame end
        for (int i = 0; i < FRAME; i++) begin
            cycle(1, i == 0, i & 255, 0, 0, 0, 0, i >= 50);
            if (i < FRAME - 1) checkValue("pending frozen", frozen, 0);
        end
        checkValue("freeze boundary frame_done", frame_done, 1);
        we_count = 0;
        drw_count = 0;
        for (int i = 0; i < FRAME; i++) begin
            dvb = (i % 4 == 0);
            cycle(1, i == 0, 'h10, dvb, i % TB_H, 1, 'hA0 + (i & 15), 1);
            if (i == 0) checkValue("frozen after frame_done", frozen, 1);
            if (buf_we) we_count++;
            if (dvb) drw_count++;
        end
        checkValue("frozen frame write count", we_count, drw_count);
        // Thaw: the boundary beat itself is still suppressed
        we_count = 0;
        for (int i = 0; i < FRAME; i++) begin
            cycle(1, i == 0, 'h20, 0, 0, 0, 0, 0);
            if (buf_we) we_count++;
        end
        checkValue("thaw frame write count", we_count, 0);
        cycle(1, 0, 'h77, 0, 0, 0, 0, 0);
        checkValue("first live buf_we", buf_we, 1);
        checkValue("first live buf_wx", buf_wx, 0);
        checkValue("first live buf_wy", buf_wy, 0);

        // Randomised traffic against the model
        frz_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(149, 0) == 0) frz_r = !frz_r;
            cycle($urandom_range(9, 0) < 7, $urandom_range(299, 0) == 0, $urandom_range(255, 0),
                  $urandom_range(9, 0) < 4, $urandom_range(TB_H + 2, 0),
                  $urandom_range(TB_V + 1, 0), $urandom_range(255, 0), frz_r);
        end

        // Asynchronous reset in the middle of a frame at (7,3)
        doReset();
        checkOutput();
        for (int i = 0; i <= 67; i++) begin
            cycle(1, i == 0, 'h40, 0, 0, 0, 0, 0);
        end
        checkValue("pre-reset buf_wx", buf_wx, 7);
        checkValue("pre-reset buf_wy", buf_wy, 3);
        #1;
        reset_n = 0;
        #1;
        checkValue("async reset buf_we", buf_we, 0);
        checkValue("async reset buf_wx", buf_wx, 0);
        checkValue("async reset buf_wy", buf_wy, 0);
        checkValue("async reset buf_data", buf_data, 0);
        checkValue("async reset cam_ready", cam_ready, 0);
        idleInputs();
        @(negedge CLOCK_50);
        reset_n = 1;
        modelReset();
        @(posedge CLOCK_50);
        #1;
        checkOutput();
        cycle(1, 0, 'h3C, 0, 0, 0, 0, 0);
        checkValue("post-reset buf_we", buf_we, 1);
        checkValue("post-reset buf_wx", buf_wx, 0);
        checkValue("post-reset buf_wy", buf_wy, 0);
        checkValue("post-reset sync_err", sync_err, 0);
        cycle(1, 0, 'h3D, 0, 0, 0, 0, 0);
        checkValue("post-reset second buf_wx", buf_wx, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/green_buffer_arbiter.md
# green_buffer_arbiter

Write-side controller for the 640x480x8 green frame buffer. Two requesters share the buffer's single write port, arbitrated round-robin:
- a raster camera pixel stream, whose x/y coordinates this block generates;
- a random-access draw engine that supplies explicit coordinates.

A frame-aligned freeze control stops camera writes so a stable image can be held for processing. The block sits between the capture/draw logic and the buffer's write inputs; the buffer's read port is untouched.

## Interface
Parameters:
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- COORD_W, 11, coordinate width
- DATA_W, 8, pixel width

Ports:
- CLOCK_50  in  1  single clock, all logic on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- cam_valid  in  1  camera pixel present
- cam_ready  out  1  camera beat accepted this cycle
- cam_data  in  DATA_W  camera pixel
- cam_sof  in  1  qualifies with cam_valid; beat is pixel (0,0)
- drw_valid  in  1  draw pixel present
- drw_ready  out  1  draw beat accepted this cycle
- drw_data  in  DATA_W  draw pixel
- drw_x, drw_y  in  COORD_W  draw coordinates
- freeze_req  in  1  level; 1 = hold image, 0 = live
- buf_we  out  1  buffer write enable
- buf_data  out  DATA_W  buffer write data
- buf_wx, buf_wy  out  COORD_W  buffer write coordinates
- frozen  out  1  camera writes currently suppressed
- frame_done  out  1  one-cycle pulse, last camera pixel of a frame accepted
- sync_err  out  1  one-cycle pulse, cam_sof arrived with counters not at (0,0)
- drw_drop  out  1  one-cycle pulse, out-of-range draw beat discarded

## Operation
- Handshake: beat transfers when valid & ready.
  - cam_ready and drw_ready are combinational from the valids and the priority pointer.
  - A requester never sees ready without its own valid.
- Arbitration, when not frozen:
  - Single requester valid: it is granted.
  - Both valid: the pointer side wins, then the pointer moves to the loser.
  - Pointer is unchanged when there is no contention.
  - Reset pointer = camera.
- Camera counters cam_x, cam_y (internal, COORD_W), advanced on every accepted camera beat:
  - cam_sof beat: written at (0,0); counters become (1,0). If counters were not (0,0), pulse sync_err.
  - Otherwise: written at (cam_x,cam_y). x increments; at H_ACTIVE-1, x wraps to 0 and y increments.
  - At (H_ACTIVE-1, V_ACTIVE-1): both wrap to 0 and frame_done pulses.
- Draw beats:
  - drw_x < H_ACTIVE and drw_y < V_ACTIVE: written at (drw_x, drw_y).
  - Otherwise: consumed with no write, drw_drop pulses.
  - Dropped beats still win or lose arbitration normally.
- Freeze FSM, states RUN, FRZ_PEND, FROZEN, THAW_PEND:
  - RUN -> FRZ_PEND when freeze_req=1.
  - FRZ_PEND -> FROZEN at the next frame boundary. A frame boundary is an accepted beat that fires frame_done or carries cam_sof. The boundary beat itself is written.
  - FRZ_PEND -> RUN if freeze_req drops before a boundary.
  - FROZEN -> THAW_PEND when freeze_req=0.
  - THAW_PEND -> RUN at the next frame boundary. The boundary beat is not written; the first written beat is the one after it.
  - THAW_PEND -> FROZEN if freeze_req rises before a boundary.
  - frozen = 1 in FROZEN and THAW_PEND.
- While frozen:
  - cam_ready = cam_valid, with no contention; counters still advance.
  - No camera write is issued.
  - Draw has the write port alone; drw_ready = drw_valid.
  - Pointer is held.

## Timing
- Write latency is 1 cycle. An accepted beat at edge N produces buf_we/buf_data/buf_wx/buf_wy valid during cycle N+1.
  - Write outputs are registered.
  - buf_we is high for exactly one cycle per written beat.
- Throughput is one write per cycle total. Back-to-back beats from either requester are allowed.
- frame_done, sync_err and drw_drop are registered and aligned with the buf_we cycle of their beat.
- Reset values while reset_n=0 and after release:
  - buf_we=0, buf_data=0, buf_wx=0, buf_wy=0
  - frame_done=0, sync_err=0, drw_drop=0
  - frozen=0, state RUN, counters (0,0), pointer=camera
  - cam_ready=0 and drw_ready=0 while in reset.
- Asynchronous reset mid-frame: the pending write is discarded and counters return to (0,0). The first camera beat after release is written at (0,0) whether or not cam_sof is set.
- Simultaneous freeze_req transition and boundary beat: the FSM uses the freeze_req value sampled on that edge.

## Test plan
- Camera only, 640x480 beats, sof on the first: buf_wy=0 and buf_wx counts 0..639, wrapping to (0,1); the last write is at (639,479); frame_done pulses once, with that write.
- Both valid every cycle, both not frozen: grants alternate cam, drw, cam, drw; buf_we is high every cycle after the first.
- Draw beat at (640,10), then (639,479) with data 0x5A: first is dropped (drw_drop=1, no buf_we); second writes 0x5A at (639,479).
- freeze_req set mid-frame: writes continue to the end of that frame; frozen=1 the cycle after frame_done; the whole next frame produces no camera buf_we; draw writes still pass.
- cam_sof injected at counters (100,3): sync_err pulses and the write goes to (0,0); the next camera beat writes to (1,0).
- Assert reset_n mid-frame at (200,50): all outputs go to 0 immediately; after release, an unflagged beat writes at (0,0).
